// File: rtl/ram_loader.sv
// ram_loader: streams bytes into the bus RAM at addresses 0..last_addr,
// optionally reading each one back, while holding the CPU off the bus.
module ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mar_load,
    output logic              ram_load,
    output logic              ram_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_WRITE, S_VERIFY} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d, err_addr_q, err_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d, error_q, error_d;
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        data_d     = data_q;
        done_d     = done_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_WAIT;
                addr_d     = '0;
                last_d     = last_addr;
                done_d     = 1'b0;
                error_d    = 1'b0;
                err_addr_d = '0;
            end
            S_WAIT: if (in_valid) begin
                data_d  = in_data;
                state_d = S_ADDR;
            end
            S_ADDR: state_d = S_WRITE;
            S_WRITE, S_VERIFY: begin
                // the next-address decision is folded into the WRITE/VERIFY exit edge
                if (state_q == S_WRITE && VERIFY) begin
                    state_d = S_VERIFY;
                end else if (state_q == S_VERIFY && bus_in != data_q) begin
                    state_d    = S_IDLE;
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                end else if (addr_q == last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            data_q     <= data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end
    assign in_ready = state_q == S_WAIT;
    assign busy     = state_q != S_IDLE;
    assign mar_load = state_q == S_ADDR;
    assign ram_load = state_q == S_WRITE;
    assign ram_out  = state_q == S_VERIFY;
    assign bus_oe   = mar_load || ram_load;
    assign bus_out  = mar_load ? DATA_W'(addr_q) : ram_load ? data_q : '0;
    assign done     = done_q;
    assign error    = error_q;
    assign err_addr = err_addr_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized and directed loads against a transaction-level model
// of the loader plus a 16-byte bus RAM driven by the DUT strobes.
module tb_ram_loader;
    logic clk, clr_n, start, in_valid, in_ready, bus_oe, mar_load, ram_load, ram_out, busy, done, error;
    logic [3:0] last_addr, err_addr;
    logic [7:0] in_data, bus_out, bus_in;
    logic start1, in_valid1, in_ready1, bus_oe1, mar_load1, ram_load1, ram_out1, busy1, done1, error1;
    logic [3:0] last_addr1, err_addr1;
    logic [7:0] in_data1, bus_out1, bus_in1;
    logic [3:0] mar0, mar1, fadr;
    logic [7:0] ram0[16], ram1[16];
    logic fen;
    int checks = 0, errors = 0;
    int gmin, gmax, run, mar_cnt, ld_cnt, out_cnt;
    logic [7:0] mar_bus, ld_bus;

    ram_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY(1'b1)) u0 (
        .clk(clk), .clr_n(clr_n), .start(start), .last_addr(last_addr), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .mar_load(mar_load), .ram_load(ram_load), .ram_out(ram_out), .busy(busy), .done(done),
        .error(error), .err_addr(err_addr));
    ram_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY(1'b0)) u1 (
        .clk(clk), .clr_n(clr_n), .start(start1), .last_addr(last_addr1), .in_data(in_data1),
        .in_valid(in_valid1), .in_ready(in_ready1), .bus_out(bus_out1), .bus_oe(bus_oe1), .bus_in(bus_in1),
        .mar_load(mar_load1), .ram_load(ram_load1), .ram_out(ram_out1), .busy(busy1), .done(done1),
        .error(error1), .err_addr(err_addr1));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Bus RAMs: MAR and write latch on the posedge the strobes are high
    always @(posedge clk) begin
        if (mar_load) mar0 <= bus_out[3:0];
        if (ram_load) ram0[mar0] <= bus_out;
        if (mar_load1) mar1 <= bus_out1[3:0];
        if (ram_load1) ram1[mar1] <= bus_out1;
    end
    assign bus_in  = bus_oe ? bus_out : ram_out ? ((fen && mar0 == fadr) ? 8'h00 : ram0[mar0]) : 8'h00;
    assign bus_in1 = bus_oe1 ? bus_out1 : ram_out1 ? ram1[mar1] : 8'h00;

    // Transaction model: after each accepted byte, a queue of bus phases (1=addr, 2=write, 3=readback)
    bit m_busy = 0, m_done = 0, m_err = 0, armed = 0;
    logic [3:0] m_addr = 0, m_last = 0, m_eaddr = 0;
    logic [7:0] m_data = 0, mram[16];
    int q[$];
    initial begin
        int f;
        logic [7:0] rb;
        forever begin
            @(posedge clk);
            if (!clr_n) begin
                armed = 1; m_busy = 0; m_done = 0; m_err = 0; m_eaddr = 0; m_addr = 0; m_data = 0;
                q.delete();
            end else if (q.size() > 0) begin
                f = q.pop_front();
                if (f == 2) mram[m_addr] = m_data;
                if (f == 3) begin
                    rb = (fen && m_addr == fadr) ? 8'h00 : mram[m_addr];
                    if (rb != m_data) begin
                        m_err = 1; m_eaddr = m_addr; m_busy = 0;
                    end else if (m_addr == m_last) begin
                        m_done = 1; m_busy = 0;
                    end else m_addr = m_addr + 1;
                end
            end else if (m_busy) begin
                if (in_valid) begin
                    m_data = in_data;
                    q.push_back(1); q.push_back(2); q.push_back(3);
                end
            end else if (start) begin
                m_busy = 1; m_addr = 0; m_last = last_addr; m_done = 0; m_err = 0; m_eaddr = 0;
            end
        end
    end

    // Per-cycle compare plus exclusivity rules
    initial begin
        int f;
        logic [19:0] e, a;
        forever begin
            @(negedge clk);
            if (armed) begin
                f = q.size() > 0 ? q[0] : 0;
                e = {m_busy && f == 0, m_busy, f == 1 || f == 2, f == 1, f == 2, f == 3, m_done, m_err, m_eaddr,
                     f == 1 ? {4'h0, m_addr} : f == 2 ? m_data : 8'h00};
                a = {in_ready, busy, bus_oe, mar_load, ram_load, ram_out, done, error, err_addr,
                     bus_oe ? bus_out : 8'h00};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, a, e);
                end
                checks++;
                if ($countones({mar_load, ram_load, ram_out}) > 1 || (bus_oe && ram_out) || (bus_oe && !busy) ||
                    $countones({mar_load1, ram_load1, ram_out1}) > 1 || (bus_oe1 && ram_out1) || (bus_oe1 && !busy1)) begin
                    errors++;
                    $display("FAIL exclusivity t=%0t: got strobes %b%b%b oe %b busy %b / %b%b%b oe %b busy %b, required legal",
                             $time, mar_load, ram_load, ram_out, bus_oe, busy, mar_load1, ram_load1, ram_out1, bus_oe1, busy1);
                end
            end
        end
    end

    // Activity monitor: in_ready gap lengths and strobe counts
    initial begin
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (run > 0) begin
                    gmin = run < gmin ? run : gmin;
                    gmax = run > gmax ? run : gmax;
                end
                run = 0;
            end else run = busy ? run + 1 : 0;
            if (mar_load) begin mar_cnt++; mar_bus = bus_out; end
            if (ram_load) begin ld_cnt++; ld_bus = bus_out; end
            if (ram_out) out_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        mar_cnt = 0; ld_cnt = 0; out_cnt = 0; mar_bus = 8'hff; ld_bus = 8'hff;
    endtask

    task automatic do_start(input logic [3:0] l);
        @(negedge clk);
        start = 1; last_addr = l;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit noise);
        int n;
        repeat (gap) begin
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        start = 0; in_valid = 1; in_data = b; n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0; in_data = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int n;
        logic [3:0] l;
        clr_n = 0; start = 0; last_addr = 0; in_data = 0; in_valid = 0; fen = 0; fadr = 0;
        start1 = 0; last_addr1 = 0; in_data1 = 0; in_valid1 = 0; run = 0; gmin = 99; gmax = 0;
        clr_mon();
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({in_ready, busy, bus_oe, mar_load, ram_load, ram_out, done, error, err_addr}), 0);
        chk("reset_outputs_v0", int'({in_ready1, busy1, bus_oe1, mar_load1, ram_load1, ram_out1, done1, error1}), 0);
        clr_n = 1;
        // full 16-byte load, back-to-back stream
        gmin = 99; gmax = 0;
        do_start(4'd15);
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 0, 0);
        wait_idle();
        chk("t1_gap_min", gmin, 3);
        chk("t1_gap_max", gmax, 3);
        chk("t1_done", int'(done), 1);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_ram[%0d]", i), int'(ram0[i]), 8'h10 + i);
        // single-byte load
        clr_mon();
        do_start(4'd0);
        send(8'hA5, 2, 0);
        wait_idle();
        chk("t2_mar_cnt", mar_cnt, 1);
        chk("t2_ld_cnt", ld_cnt, 1);
        chk("t2_mar_bus", int'(mar_bus), 8'h00);
        chk("t2_ld_bus", int'(ld_bus), 8'hA5);
        chk("t2_done_busy", int'({done, busy}), 2'b10);
        // read-back fault at address 3
        fen = 1; fadr = 4'd3;
        do_start(4'd15);
        for (int i = 0; i < 4; i++) send(8'(8'h11 * i), 1, 1);
        wait_idle();
        fen = 0;
        clr_mon();
        in_valid = 1;
        repeat (10) begin in_data = $urandom; @(negedge clk); end
        in_valid = 0;
        chk("t3_err_flags", int'({error, done}), 2'b10);
        chk("t3_err_addr", int'(err_addr), 3);
        chk("t3_strobes_after", mar_cnt + ld_cnt + out_cnt, 0);
        // reset during WRITE of address 5, then reload
        do_start(4'd15);
        for (int i = 0; i < 6; i++) send(8'($urandom), 0, 0);
        @(negedge clk);
        chk("t4_in_write", int'(ram_load), 1);
        clr_n = 0;
        @(negedge clk);
        chk("t4_after_reset", int'({mar_load, ram_load, ram_out, bus_oe, busy, done, error}), 0);
        clr_n = 1;
        do_start(4'd15);
        for (int i = 0; i < 16; i++) send(8'($urandom), $urandom_range(0, 3), 1);
        wait_idle();
        chk("t4_done", int'(done), 1);
        for (int i = 0; i < 16; i++) chk($sformatf("t4_ram[%0d]", i), int'(ram0[i]), int'(mram[i]));
        // start during WAIT, long idle stream
        do_start(4'd15);
        clr_mon();
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (20) @(negedge clk);
        chk("t5_waiting", int'({in_ready, busy}), 2'b11);
        chk("t5_no_strobes", mar_cnt + ld_cnt + out_cnt, 0);
        for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 0, 0);
        wait_idle();
        chk("t5_done", int'(done), 1);
        chk("t5_ram[15]", int'(ram0[15]), 8'hCF);
        // random partial loads
        repeat (4) begin
            l = 4'($urandom_range(0, 15));
            do_start(l);
            for (int i = 0; i <= int'(l); i++) send(8'($urandom), $urandom_range(0, 3), 1);
            wait_idle();
            chk("rnd_done", int'(done), 1);
            for (int i = 0; i <= int'(l); i++) chk($sformatf("rnd_ram[%0d]", i), int'(ram0[i]), int'(mram[i]));
        end
        // no read-back variant: 2-cycle in_ready gap
        @(negedge clk);
        start1 = 1; last_addr1 = 4'd3;
        @(negedge clk);
        start1 = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid1 = 1; in_data1 = 8'(8'h40 + k); n = 0;
            while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("v0_timeout", 0, 1);
            @(negedge clk);
            in_valid1 = 0; n = 0;
            while (!in_ready1 && busy1 && n < 10) begin n++; @(negedge clk); end
            chk($sformatf("v0_gap%0d", k), n, 2);
        end
        chk("v0_done", int'({done1, busy1, error1}), 3'b100);
        for (int i = 0; i < 4; i++) chk($sformatf("v0_ram[%0d]", i), int'(ram1[i]), 8'h40 + i);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
